// File: rtl/mel_log_compress.sv
// Frame-buffered fixed-point log2 compressor for mel filterbank energies.
// Leading-one detector plus linear mantissa; streams one band per handshake.
module mel_log_compress #(
  parameter int NUM_BANDS = 13,
  parameter int IN_W      = 16,
  parameter int FRAC_W    = 8,
  parameter int OUT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mel_in_valid,
  output logic                      mel_in_ready,
  input  logic [NUM_BANDS*IN_W-1:0] mel_in,
  output logic                      log_valid,
  input  logic                      log_ready,
  output logic [OUT_W-1:0]          log_data,
  output logic [3:0]                log_band,
  output logic                      log_last,
  output logic                      clamp_flag,
  input  logic                      clamp_clr
);

  localparam int NW = IN_W - 2;
  localparam logic [3:0] LAST_BAND = 4'(NUM_BANDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, OUT = 2'd2} state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [NUM_BANDS*IN_W-1:0] buf_r;
  logic                      load_frame_s;
  logic                      load_band_s;
  logic                      end_frame_s;
  logic [3:0]                band_sel_s;
  logic [IN_W-1:0]           band_val_s;
  logic                      clamp_set_s;

  // Non-positive inputs clamp to 0; otherwise {msb position, next FRAC_W bits below the msb}.
  function automatic logic [OUT_W-1:0] log2_fx(input logic [IN_W-1:0] x);
    int                p;
    logic [NW-1:0]     n;
    logic [FRAC_W-1:0] frac;
    p    = 0;
    n    = '0;
    frac = '0;
    if (!x[IN_W-1] && (x != '0)) begin
      for (int i = 0; i < IN_W-1; i++) begin
        if (x[i]) p = i;
      end
      n    = NW'(x << (IN_W-2-p));
      frac = FRAC_W'(n >> (NW-FRAC_W));
      return (OUT_W'(p) << FRAC_W) | OUT_W'(frac);
    end else begin
      return '0;
    end
  endfunction

  assign mel_in_ready = (state_r == IDLE);
  assign band_val_s   = buf_r[int'(band_sel_s)*IN_W +: IN_W];
  assign clamp_set_s  = load_band_s && (band_val_s[IN_W-1] || (band_val_s == '0));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (mel_in_valid) state_nxt_s = LOAD; else state_nxt_s = IDLE;
      LOAD:    state_nxt_s = OUT;
      OUT:     if (log_ready && log_last) state_nxt_s = IDLE; else state_nxt_s = OUT;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath strobes; a handshake in OUT reloads the next band on the same edge.
  always_comb begin
    load_frame_s = 1'b0;
    load_band_s  = 1'b0;
    end_frame_s  = 1'b0;
    band_sel_s   = log_band + 4'd1;
    case (state_r)
      IDLE: load_frame_s = mel_in_valid;
      LOAD: begin
        load_band_s = 1'b1;
        band_sel_s  = 4'd0;
      end
      OUT: begin
        load_band_s = log_ready && !log_last;
        end_frame_s = log_ready && log_last;
      end
      default: load_frame_s = 1'b0;
    endcase
  end

  // Frame buffer, registered output beat and sticky clamp flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r      <= '0;
      log_valid  <= 1'b0;
      log_data   <= '0;
      log_band   <= 4'd0;
      log_last   <= 1'b0;
      clamp_flag <= 1'b0;
    end else begin
      if (load_frame_s) buf_r <= mel_in;
      if (load_band_s) begin
        log_valid <= 1'b1;
        log_data  <= log2_fx(band_val_s);
        log_band  <= band_sel_s;
        log_last  <= (band_sel_s == LAST_BAND);
      end else if (end_frame_s) begin
        log_valid <= 1'b0;
        log_last  <= 1'b0;
      end
      if (clamp_set_s)    clamp_flag <= 1'b1;
      else if (clamp_clr) clamp_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mel_log_compress.sv
// Randomized self-checking bench for mel_log_compress against an arithmetic log2 model.
module tb_mel_log_compress;
  localparam int NB = 13;
  localparam int IW = 16;
  localparam int OW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mel_in_valid = 1'b0;
  logic              mel_in_ready;
  logic [NB*IW-1:0]  mel_in = '0;
  logic              log_valid;
  logic              log_ready = 1'b0;
  logic [OW-1:0]     log_data;
  logic [3:0]        log_band;
  logic              log_last;
  logic              clamp_flag;
  logic              clamp_clr = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [OW-1:0] q_data[$];
  logic [3:0]    q_band[$];
  logic          q_last[$];
  int first_valid, end_cyc, stall_err, rdy_err;
  bit timeout;
  int fr [NB];
  int fr2 [NB];

  mel_log_compress dut (
    .clk(clk), .rst(rst), .mel_in_valid(mel_in_valid), .mel_in_ready(mel_in_ready),
    .mel_in(mel_in), .log_valid(log_valid), .log_ready(log_ready), .log_data(log_data),
    .log_band(log_band), .log_last(log_last), .clamp_flag(clamp_flag), .clamp_clr(clamp_clr)
  );

  always #5 clk = ~clk;

  // Reference: floor(log2 x) integer part, linear fraction (x-2^p)/2^p scaled by 256.
  function automatic int ref_log2(input int x);
    int p;
    if (x <= 0) return 0;
    p = 0;
    while ((x >> (p + 1)) != 0) p++;
    return p * 256 + ((x - (1 << p)) * 256) / (1 << p);
  endfunction

  function automatic logic [NB*IW-1:0] pack_frame(input int f [NB]);
    logic [NB*IW-1:0] v;
    v = '0;
    for (int k = 0; k < NB; k++) v[k*IW +: IW] = IW'(f[k]);
    return v;
  endfunction

  task automatic gen_frame(input bit allow_nonpos);
    int raw;
    for (int k = 0; k < NB; k++) begin
      if (allow_nonpos) begin
        raw = int'($urandom_range(0, 65535)) >> $urandom_range(0, 15);
        fr[k] = (raw > 32767) ? raw - 65536 : raw;
      end else begin
        raw = int'($urandom_range(1, 32767)) >> $urandom_range(0, 14);
        fr[k] = (raw == 0) ? 1 : raw;
      end
    end
  endtask

  // Present a frame at a negedge and wait for its capture edge; leaves valid at 'hold'.
  task automatic start_frame(input logic [NB*IW-1:0] f, input bit hold);
    int w = 0;
    while (mel_in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      checks++;
      errors++;
      $display("FAIL start_frame_timeout mel_in_ready=%b required=1", mel_in_ready);
    end
    mel_in = f;
    mel_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mel_in_valid = hold;
  endtask

  // Record accepted beats until log_last handshake; cycle 0 is the negedge after capture.
  task automatic collect(input bit rnd_ready, input bit intrude, input logic [NB*IW-1:0] other);
    int cyc = 0;
    bit done = 1'b0;
    bit stall = 1'b0;
    bit r;
    logic [OW-1:0] hd;
    logic [3:0] hb;
    logic hl;
    q_data.delete();
    q_band.delete();
    q_last.delete();
    first_valid = -1;
    stall_err = 0;
    rdy_err = 0;
    while (!done && cyc < 400) begin
      if (intrude) begin
        mel_in_valid = 1'b1;
        mel_in = other;
      end
      if (log_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (stall && (log_valid !== 1'b1 || log_data !== hd || log_band !== hb || log_last !== hl))
        stall_err++;
      if (mel_in_ready !== 1'b0) rdy_err++;
      r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      log_ready = r;
      if (log_valid === 1'b1 && r) begin
        q_data.push_back(log_data);
        q_band.push_back(log_band);
        q_last.push_back(log_last);
        if (log_last === 1'b1) done = 1'b1;
      end
      stall = (log_valid === 1'b1) && !r;
      hd = log_data;
      hb = log_band;
      hl = log_last;
      @(negedge clk);
      cyc++;
    end
    if (intrude) mel_in_valid = 1'b0;
    end_cyc = cyc;
    timeout = !done;
    log_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (log_valid !== 1'b0 || log_data !== 16'h0000 || log_band !== 4'd0 || log_last !== 1'b0 ||
        clamp_flag !== 1'b0 || mel_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state valid=%b data=%h band=%0d last=%b clamp=%b rdy=%b required 0,0000,0,0,0,1",
               log_valid, log_data, log_band, log_last, clamp_flag, mel_in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    for (int k = 0; k < NB; k++) fr[k] = 1 << k;
    start_frame(pack_frame(fr), 1'b0);
    collect(1'b0, 1'b0, '0);
    checks++;
    if (timeout || q_data.size() != NB) begin
      errors++;
      $display("FAIL ramp_count beats=%0d required=%0d", q_data.size(), NB);
    end
    checks++;
    if (first_valid != 1) begin
      errors++;
      $display("FAIL ramp_latency first_valid_cycle=%0d required=1", first_valid);
    end
    for (int k = 0; k < q_data.size() && k < NB; k++) begin
      checks++;
      if (q_data[k] !== OW'(k * 256) || q_band[k] !== 4'(k) || q_last[k] !== (k == NB-1)) begin
        errors++;
        $display("FAIL ramp_beat%0d data=%h band=%0d last=%b required %h,%0d,%b",
                 k, q_data[k], q_band[k], q_last[k], OW'(k * 256), k, (k == NB-1));
      end
    end
  endtask

  task automatic test_mantissa();
    gen_frame(1'b0);
    fr[0] = 32'h0180;
    fr[1] = 32'h7FFF;
    fr[2] = 32'h0001;
    start_frame(pack_frame(fr), 1'b0);
    collect(1'b0, 1'b0, '0);
    checks++;
    if (timeout || q_data.size() != NB) begin
      errors++;
      $display("FAIL mant_count beats=%0d required=%0d", q_data.size(), NB);
    end else begin
      checks++;
      if (q_data[0] !== 16'h0880 || q_data[1] !== 16'h0EFF || q_data[2] !== 16'h0000) begin
        errors++;
        $display("FAIL mant_fixed got %h %h %h required 0880 0EFF 0000", q_data[0], q_data[1], q_data[2]);
      end
    end
    for (int k = 0; k < q_data.size() && k < NB; k++) begin
      checks++;
      if (q_data[k] !== OW'(ref_log2(fr[k])) || q_band[k] !== 4'(k) || q_last[k] !== (k == NB-1)) begin
        errors++;
        $display("FAIL mant_beat%0d data=%h band=%0d last=%b required %h,%0d,%b",
                 k, q_data[k], q_band[k], q_last[k], OW'(ref_log2(fr[k])), k, (k == NB-1));
      end
    end
    checks++;
    if (clamp_flag !== 1'b0) begin
      errors++;
      $display("FAIL mant_no_clamp clamp_flag=%b required=0", clamp_flag);
    end
  endtask

  task automatic test_clamp();
    clamp_clr = 1'b1;
    @(negedge clk);
    clamp_clr = 1'b0;
    gen_frame(1'b0);
    fr[3] = 0;
    fr[4] = -5;
    start_frame(pack_frame(fr), 1'b0);
    collect(1'b0, 1'b0, '0);
    checks++;
    if (timeout || q_data.size() != NB) begin
      errors++;
      $display("FAIL clamp_count beats=%0d required=%0d", q_data.size(), NB);
    end else begin
      checks++;
      if (q_data[3] !== 16'h0000 || q_data[4] !== 16'h0000) begin
        errors++;
        $display("FAIL clamp_values got %h %h required 0000 0000", q_data[3], q_data[4]);
      end
    end
    for (int k = 0; k < q_data.size() && k < NB; k++) begin
      checks++;
      if (q_data[k] !== OW'(ref_log2(fr[k])) || q_band[k] !== 4'(k)) begin
        errors++;
        $display("FAIL clamp_beat%0d data=%h band=%0d required %h,%0d",
                 k, q_data[k], q_band[k], OW'(ref_log2(fr[k])), k);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (clamp_flag !== 1'b1) begin
      errors++;
      $display("FAIL clamp_sticky clamp_flag=%b required=1", clamp_flag);
    end
    clamp_clr = 1'b1;
    @(negedge clk);
    clamp_clr = 1'b0;
    checks++;
    if (clamp_flag !== 1'b0) begin
      errors++;
      $display("FAIL clamp_clear clamp_flag=%b required=0", clamp_flag);
    end
  endtask

  task automatic test_backpressure();
    logic [NB*IW-1:0] other;
    for (int f = 0; f < 3; f++) begin
      gen_frame(1'b1);
      fr2 = fr;
      other = pack_frame(fr2);
      gen_frame(1'b1);
      start_frame(pack_frame(fr), 1'b0);
      collect(1'b1, 1'b1, other);
      checks++;
      if (timeout || q_data.size() != NB || stall_err != 0 || rdy_err != 0) begin
        errors++;
        $display("FAIL bp_frame%0d beats=%0d stall_err=%0d rdy_err=%0d required %0d,0,0",
                 f, q_data.size(), stall_err, rdy_err, NB);
      end
      for (int k = 0; k < q_data.size() && k < NB; k++) begin
        checks++;
        if (q_data[k] !== OW'(ref_log2(fr[k])) || q_band[k] !== 4'(k) || q_last[k] !== (k == NB-1)) begin
          errors++;
          $display("FAIL bp_beat%0d data=%h band=%0d last=%b required %h,%0d,%b",
                   k, q_data[k], q_band[k], q_last[k], OW'(ref_log2(fr[k])), k, (k == NB-1));
        end
      end
      repeat (3) @(negedge clk);
      checks++;
      if (log_valid !== 1'b0 || mel_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_idle%0d log_valid=%b mel_in_ready=%b required 0,1", f, log_valid, mel_in_ready);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int w = 0;
    gen_frame(1'b0);
    start_frame(pack_frame(fr), 1'b0);
    log_ready = 1'b1;
    while (!(log_valid === 1'b1 && log_band === 4'd5) && w < 40) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (w >= 40 || log_valid !== 1'b0 || mel_in_ready !== 1'b1 || log_band !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid wait=%0d log_valid=%b mel_in_ready=%b band=%0d required valid=0 rdy=1 band=0",
               w, log_valid, mel_in_ready, log_band);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (log_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_partial log_valid=%b required=0", log_valid);
    end
    log_ready = 1'b0;
    gen_frame(1'b0);
    start_frame(pack_frame(fr), 1'b0);
    collect(1'b0, 1'b0, '0);
    checks++;
    if (timeout || q_data.size() != NB || q_band[0] !== 4'd0) begin
      errors++;
      $display("FAIL rst_restart beats=%0d first_band=%0d required %0d,0", q_data.size(),
               (q_band.size() > 0) ? q_band[0] : 4'd15, NB);
    end
    for (int k = 0; k < q_data.size() && k < NB; k++) begin
      checks++;
      if (q_data[k] !== OW'(ref_log2(fr[k])) || q_band[k] !== 4'(k)) begin
        errors++;
        $display("FAIL rst_beat%0d data=%h band=%0d required %h,%0d",
                 k, q_data[k], q_band[k], OW'(ref_log2(fr[k])), k);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NB*IW-1:0] f2;
    gen_frame(1'b1);
    fr2 = fr;
    f2 = pack_frame(fr2);
    gen_frame(1'b1);
    start_frame(pack_frame(fr), 1'b1);
    mel_in = f2;
    collect(1'b0, 1'b0, '0);
    checks++;
    // last handshake edge is capture+NB+1, so the next capture lands NB+2 edges after the first
    if (timeout || q_data.size() != NB || end_cyc != NB + 1 || mel_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_frame1 beats=%0d end_cyc=%0d rdy=%b required %0d,%0d,1",
               q_data.size(), end_cyc, mel_in_ready, NB, NB + 1);
    end
    for (int k = 0; k < q_data.size() && k < NB; k++) begin
      checks++;
      if (q_data[k] !== OW'(ref_log2(fr[k])) || q_band[k] !== 4'(k)) begin
        errors++;
        $display("FAIL b2b1_beat%0d data=%h band=%0d required %h,%0d",
                 k, q_data[k], q_band[k], OW'(ref_log2(fr[k])), k);
      end
    end
    fr = fr2;
    @(posedge clk);
    @(negedge clk);
    mel_in_valid = 1'b0;
    collect(1'b0, 1'b0, '0);
    checks++;
    if (timeout || q_data.size() != NB || first_valid != 1) begin
      errors++;
      $display("FAIL b2b_frame2 beats=%0d first_valid=%0d required %0d,1", q_data.size(), first_valid, NB);
    end
    for (int k = 0; k < q_data.size() && k < NB; k++) begin
      checks++;
      if (q_data[k] !== OW'(ref_log2(fr[k])) || q_band[k] !== 4'(k) || q_last[k] !== (k == NB-1)) begin
        errors++;
        $display("FAIL b2b2_beat%0d data=%h band=%0d last=%b required %h,%0d,%b",
                 k, q_data[k], q_band[k], q_last[k], OW'(ref_log2(fr[k])), k, (k == NB-1));
      end
    end
  endtask

  task automatic test_random();
    bit exp_flag = 1'b0;
    clamp_clr = 1'b1;
    @(negedge clk);
    clamp_clr = 1'b0;
    for (int f = 0; f < 5; f++) begin
      gen_frame(1'b1);
      for (int k = 0; k < NB; k++) if (fr[k] <= 0) exp_flag = 1'b1;
      start_frame(pack_frame(fr), 1'b0);
      collect(1'b1, 1'b0, '0);
      checks++;
      if (timeout || q_data.size() != NB || stall_err != 0 || clamp_flag !== exp_flag) begin
        errors++;
        $display("FAIL rand_frame%0d beats=%0d stall_err=%0d clamp=%b required %0d,0,%b",
                 f, q_data.size(), stall_err, clamp_flag, NB, exp_flag);
      end
      for (int k = 0; k < q_data.size() && k < NB; k++) begin
        checks++;
        if (q_data[k] !== OW'(ref_log2(fr[k])) || q_band[k] !== 4'(k) || q_last[k] !== (k == NB-1)) begin
          errors++;
          $display("FAIL rand_beat%0d_%0d x=%0d data=%h band=%0d last=%b required %h,%0d,%b",
                   f, k, fr[k], q_data[k], q_band[k], q_last[k], OW'(ref_log2(fr[k])), k, (k == NB-1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_mantissa();
    test_clamp();
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
